// File: rtl/dmem_resp.sv
// Data-memory responder: byte-strobed word RAM plus MMIO console TX FIFO, STATUS and TOHOST.
// Optional free-running cycle counter at MMIO offset 3 when DMEM_RESP_CYCLE_CNT_EN is defined.
module dmem_resp #(
  parameter int              XLEN       = 32,
  parameter int              XBYTES     = XLEN/8,
  parameter int              RAM_AW     = 12,
  parameter logic [XLEN-1:0] MMIO_BASE  = 32'h40000000,
  parameter int              FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              stall_o,
  input  logic [XLEN-1:0]   dmem_addr_i,
  input  logic              dmem_wvalid_i,
  input  logic [XLEN-1:0]   dmem_wdata_i,
  input  logic [XBYTES-1:0] dmem_wstrb_i,
  output logic [XLEN-1:0]   dmem_rdata_o,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_ready_i,
  output logic              halt_o,
  output logic [XLEN-1:0]   tohost_o
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic              mmio_hit;
  logic [1:0]        off;
  logic [RAM_AW-1:0] idx;
  logic              ram_we, push, pop, full, empty, tohost_we;
  logic [PW:0]       wptr, rptr, count;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [XBYTES-1:0][7:0] ram_rd;
  logic [XLEN-1:0]   ram_word, mmio_word;
  logic              unused;

  assign mmio_hit  = dmem_addr_i[XLEN-1:4] == MMIO_BASE[XLEN-1:4];
  assign off       = dmem_addr_i[3:2];
  assign idx       = dmem_addr_i[RAM_AW+1:2];
  assign unused    = ^dmem_addr_i[1:0];

  assign ram_we    = dmem_wvalid_i & ~mmio_hit;
  assign tohost_we = dmem_wvalid_i & mmio_hit & (off == 2'd2);

  // Stall is purely from inputs and FIFO state, so it cannot loop through the core.
  assign count   = wptr - rptr;
  assign full    = count == (PW+1)'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign stall_o = dmem_wvalid_i & mmio_hit & (off == 2'd0) & full;
  assign push    = dmem_wvalid_i & mmio_hit & (off == 2'd0) & ~full;
  assign pop     = ~empty & tx_ready_i;

  assign tx_valid_o = ~empty;
  assign tx_data_o  = empty ? 8'h00 : fifo_mem[rptr[PW-1:0]];

  always_ff @(posedge clk_i)
    if (push) fifo_mem[wptr[PW-1:0]] <= dmem_wdata_i[7:0];

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end

  // One byte-wide RAM per lane; the async read gives old data on same-cycle write.
  for (genvar i = 0; i < XBYTES; i++) begin : g_lane
    logic [7:0] mem [2**RAM_AW];
    always_ff @(posedge clk_i)
      if (ram_we && dmem_wstrb_i[i]) mem[idx] <= dmem_wdata_i[8*i +: 8];
    assign ram_rd[i] = mem[idx];
  end
  assign ram_word = ram_rd;

`ifdef DMEM_RESP_CYCLE_CNT_EN
  logic [31:0] cyc_cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cyc_cnt <= '0;
    else         cyc_cnt <= cyc_cnt + 32'd1;
`endif

  always_comb begin
    mmio_word = '0;
    case (off)
      2'd1: mmio_word = XLEN'({8'(count), 6'b0, empty, full});
      2'd2: mmio_word = tohost_o;
`ifdef DMEM_RESP_CYCLE_CNT_EN
      2'd3: mmio_word = XLEN'(cyc_cnt);
`endif
      default: mmio_word = '0;
    endcase
  end

  // Read data holds while stalled so the MA-stage load keeps its value.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      dmem_rdata_o <= '0;
      halt_o       <= 1'b0;
      tohost_o     <= '0;
    end else begin
      if (!stall_o) dmem_rdata_o <= mmio_hit ? mmio_word : ram_word;
      if (tohost_we) begin
        tohost_o <= dmem_wdata_i;
        halt_o   <= 1'b1;
      end
    end
endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: RAM/strobe/alias, TX FIFO stall, TOHOST, async reset, cycle counter.
module tb_dmem_resp;
  logic        clk = 1'b0, rst_n;
  logic        stall, wvalid, tx_valid, tx_ready, halt;
  logic [31:0] addr, wdata, rdata, tohost;
  logic [3:0]  wstrb;
  logic [7:0]  tx_data;
  int          checks = 0, errors = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  tx_q [$];
  logic [31:0] c0;

  dmem_resp dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_o(stall),
    .dmem_addr_i(addr), .dmem_wvalid_i(wvalid), .dmem_wdata_i(wdata), .dmem_wstrb_i(wstrb),
    .dmem_rdata_o(rdata), .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .halt_o(halt), .tohost_o(tohost)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; wstrb = s; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] e, input string tag);
    addr = a; wvalid = 1'b0;
    rd_q.push_back(e);
    tick();
    chk(tag, rdata, rd_q.pop_front());
  endtask

  task automatic tx_push(input logic [7:0] b);
    addr = 32'h40000000; wdata = {24'h0, b}; wstrb = 4'b0001; wvalid = 1'b1;
    #1 chk("push_nostall", stall, 0);
    tick();
    tx_q.push_back(b);
    wvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wvalid = 1'b0; addr = '0; wdata = '0; wstrb = '0; tx_ready = 1'b0;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_txvalid", tx_valid, 0);
    chk("rst_halt", halt, 0);
    chk("rst_tohost", tohost, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // RAM full-word store and strobed byte merge
    store(32'h100, 32'hDEADBEEF, 4'b1111);
    load(32'h100, 32'hDEADBEEF, "ram_word");
    store(32'h100, 32'h11223344, 4'b1111);
    store(32'h102, 32'h00AB00AB, 4'b0100);
    load(32'h100, 32'h11AB3344, "ram_strb");
    load(32'h4100, 32'h11AB3344, "ram_alias");

    // read-before-write on the same word
    store(32'h104, 32'hAAAA5555, 4'b1111);
    addr = 32'h104; wdata = 32'h12345678; wstrb = 4'b1111; wvalid = 1'b1;
    rd_q.push_back(32'hAAAA5555);
    tick();
    wvalid = 1'b0;
    chk("rbw_old", rdata, rd_q.pop_front());
    load(32'h104, 32'h12345678, "rbw_new");

    // fill TX FIFO with consumer stalled
    store(32'h100, 32'h5, 4'b1111);
    load(32'h40000004, 32'h00000002, "status_empty");
    for (int i = 0; i < 8; i++) tx_push(8'h41 + 8'(i));
    load(32'h40000004, 32'h00000801, "status_full");
    chk("head_valid", tx_valid, 1);
    load(32'h100, 32'h5, "pre_stall_load");

    // ninth store stalls; rdata holds
    addr = 32'h40000000; wdata = 32'h49; wstrb = 4'b0001; wvalid = 1'b1;
    #1 chk("stall_on", stall, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_held", stall, 1);
      chk("rdata_hold", rdata, 32'h5);
    end
    tx_ready = 1'b1;
    chk("pop_head", tx_data, tx_q[0]);
    tick();
    void'(tx_q.pop_front());
    tx_ready = 1'b0;
    chk("stall_off", stall, 0);
    chk("rdata_hold_last", rdata, 32'h5);
    tick();
    tx_q.push_back(8'h49);
    wvalid = 1'b0;
    load(32'h40000004, 32'h00000801, "status_refill");

    // drain; 0x49 must appear exactly once
    tx_ready = 1'b1;
    while (tx_q.size() > 0) begin
      chk("drain_valid", tx_valid, 1);
      chk("drain_data", tx_data, tx_q.pop_front());
      tick();
    end
    tx_ready = 1'b0;
    chk("drain_empty", tx_valid, 0);
    load(32'h40000004, 32'h00000002, "status_drained");

    // TOHOST, status write ignored, byte store captures raw word
    store(32'h40000008, 32'h1, 4'b1111);
    chk("halt_set", halt, 1);
    chk("tohost_1", tohost, 32'h1);
    store(32'h40000004, 32'hFFFFFFFF, 4'b1111);
    load(32'h40000004, 32'h00000002, "status_ro");
    store(32'h40000008, 32'hCAFEBABE, 4'b0001);
    chk("tohost_raw", tohost, 32'hCAFEBABE);
    chk("halt_sticky", halt, 1);
    load(32'h40000008, 32'hCAFEBABE, "tohost_rd");

    // offset 3
    addr = 32'h4000000C; tick(); c0 = rdata;
    addr = 32'h0;
    repeat (9) tick();
    addr = 32'h4000000C; tick();
`ifdef DMEM_RESP_CYCLE_CNT_EN
    chk("cyc_delta", rdata - c0, 32'd10);
`else
    chk("off3_first", c0, 32'h0);
    chk("off3_second", rdata, 32'h0);
`endif

    // async reset in the middle of a stall
    for (int i = 0; i < 8; i++) tx_push(8'h60 + 8'(i));
    addr = 32'h40000000; wdata = 32'h70; wstrb = 4'b0001; wvalid = 1'b1;
    #1 chk("stall_pre_rst", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_txvalid", tx_valid, 0);
    chk("arst_halt", halt, 0);
    chk("arst_tohost", tohost, 0);
    chk("arst_rdata", rdata, 0);
    tx_q.delete();
    wvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    load(32'h40000004, 32'h00000002, "status_post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
